// File: rtl/enchimento_pkg.sv
// Shared encodings for the filling-stage controller: FSM states, alarm codes
// and the timer-width helper.
package enchimento_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    FILL    = 3'd2,
    SETTLE  = 3'd3,
    RELEASE = 3'd4,
    ALARM   = 3'd5
  } estado_t;

  localparam logic [1:0] AL_NONE    = 2'b00;
  localparam logic [1:0] AL_TANK    = 2'b01;
  localparam logic [1:0] AL_TIMEOUT = 2'b10;

  // Smallest width that holds 0..max(a,b)-1, never below one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/temporizador_enchimento.sv
// Cycle timer for the filling stage: synchronous clear wins over enable.
module temporizador_enchimento #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mef_enchimento.sv
// Filling-stage controller: conveyor to nozzle, fill until level, drip settle,
// release to sealing; counts filled bottles and latches tank/timeout alarms.
module mef_enchimento
  import enchimento_pkg::*;
#(
  parameter int unsigned FILL_MAX      = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             liga,
  input  logic             garrafa,
  input  logic             nivel,
  input  logic             reservatorio,
  input  logic             ack,
  output logic             motor,
  output logic             ev,
  output logic             done,
  output logic             alarme,
  output logic [1:0]       alarme_cod,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned TW = timer_width(FILL_MAX, SETTLE_CYCLES);
  localparam logic [TW-1:0] FILL_LAST   = TW'(FILL_MAX - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  estado_t       estado;
  estado_t       nxt;
  logic [1:0]    cod_nxt;
  logic [TW-1:0] timer;
  logic          timer_clear;
  logic          timer_en;
  logic          fill_done;

  temporizador_enchimento #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .count (timer)
  );

  // Next state and alarm code; tank loss outranks every other exit.
  always_comb begin
    nxt     = estado;
    cod_nxt = alarme_cod;
    case (estado)
      IDLE: begin
        if (liga) begin
          if (reservatorio) begin
            nxt = MOVE;
          end else begin
            nxt     = ALARM;
            cod_nxt = AL_TANK;
          end
        end
      end
      MOVE: begin
        if (!reservatorio) begin
          nxt     = ALARM;
          cod_nxt = AL_TANK;
        end else if (!liga) begin
          nxt = IDLE;
        end else if (garrafa) begin
          nxt = FILL;
        end
      end
      FILL: begin
        if (!reservatorio) begin
          nxt     = ALARM;
          cod_nxt = AL_TANK;
        end else if (nivel) begin
          nxt = SETTLE;
        end else if (timer == FILL_LAST) begin
          nxt     = ALARM;
          cod_nxt = AL_TIMEOUT;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!garrafa) begin
          nxt = liga ? MOVE : IDLE;
        end
      end
      ALARM: begin
        if (ack && reservatorio) begin
          nxt     = IDLE;
          cod_nxt = AL_NONE;
        end
      end
      default: begin
        nxt     = IDLE;
        cod_nxt = AL_NONE;
      end
    endcase
  end

  assign timer_clear = (nxt != estado);
  assign timer_en    = (estado == FILL) || (estado == SETTLE);
  assign fill_done   = (estado == SETTLE) && (nxt == RELEASE);

  // State, alarm code, completion pulse and bottle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= IDLE;
      alarme_cod <= AL_NONE;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      estado     <= nxt;
      alarme_cod <= cod_nxt;
      done       <= fill_done;
      if (fill_done) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Moore actuator decode.
  assign motor  = (estado == MOVE) || (estado == RELEASE);
  assign ev     = (estado == FILL);
  assign alarme = (estado == ALARM);

endmodule
